// File: rtl/p_hit_t_pipe_pkg.sv
// Shared types and helpers for the plane-hit t pipeline.
// Sizes here are the default build; modules carry their own parameters.
package p_hit_pkg;

   localparam int DEF_D_WIDTH = 32;
   localparam int DEF_Q_BITS  = 16;
   localparam int DIV_ITERS   = DEF_D_WIDTH + DEF_Q_BITS;
   localparam int WIDE        = 128;

   typedef enum logic [2:0] {IDLE, MUL, SUM, DIV, WRITE} state_t;

   typedef logic signed [2:0][DEF_D_WIDTH-1:0] vec3;
   typedef logic signed [WIDE-1:0] wide_t;

   // Clamp a wide signed value into the signed range of a w-bit word.
   function automatic wide_t sat_w(input wide_t x, input int w);
      wide_t hi, lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -hi - wide_t'(1);
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic wide_t abs_w(input wide_t x);
      return (x < 0) ? -x : x;
   endfunction

endpackage

// File: rtl/fifo_array.sv
// First-word-fall-through FIFO; a write while full is accepted only
// when a read happens on the same edge.
module fifo_array #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic             wr_ok, rd_ok;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/p_hit_t_pipe_div.sv
// Unsigned restoring divider, one quotient bit per cycle for NW cycles.
// The first bit is resolved on the start edge; done pulses with the last.
module p_hit_seq_div #(
   parameter int NW = 48,
   parameter int DW = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [NW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [NW-1:0] quotient
);
   localparam int CW = $clog2(NW);

   logic [DW:0]   rem, r_in, r_sh, r_nx;
   logic [NW-1:0] quo, q_in, q_nx;
   logic [CW-1:0] cnt;

   always_comb begin
      r_in = start ? '0 : rem;
      q_in = start ? dividend : quo;
      r_sh = {r_in[DW-1:0], q_in[NW-1]};
      q_nx = {q_in[NW-2:0], 1'b0};
      r_nx = r_sh;
      if (r_sh >= {1'b0, divisor}) begin
         r_nx    = r_sh - {1'b0, divisor};
         q_nx[0] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
         rem  <= '0;
         quo  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem  <= r_nx;
            quo  <= q_nx;
            cnt  <= CW'(NW - 1);
            busy <= 1'b1;
         end else if (busy) begin
            rem <= r_nx;
            quo <= q_nx;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo;

endmodule

// File: rtl/p_hit_t_pipe.sv
// Ray/plane t = (n.v0 - n.origin) / (n.dir) with hit flag, FIFO in and out.
// Define P_HIT_SAT_EN to saturate num, den and t instead of wrapping.
module p_hit_t_pipe
   import p_hit_pkg::*;
#(
   parameter int D_WIDTH    = 32,
   parameter int Q_BITS     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int EPS        = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [2:0][D_WIDTH-1:0] tri_normal,
   input  logic [2:0][D_WIDTH-1:0] v0,
   input  logic [2:0][D_WIDTH-1:0] origin,
   input  logic [2:0][D_WIDTH-1:0] dir,
   input  logic                    in_wr_en,
   output logic                    in_full,
   output logic [D_WIDTH-1:0]      t_out,
   output logic                    hit_out,
   output logic                    out_empty,
   input  logic                    out_rd_en
);
   localparam int N     = D_WIDTH + Q_BITS;
   localparam int PW    = 2 * D_WIDTH;
   localparam int SW    = 2 * D_WIDTH + 3;
   localparam int REC_W = 12 * D_WIDTH;
   localparam int OUT_W = D_WIDTH + 1;

   state_t                  state;
   logic [REC_W-1:0]        in_head;
   logic                    in_empty, in_rd;
   logic [2:0][D_WIDTH-1:0] op_n, op_v, op_o, op_d;
   logic [2:0][PW-1:0]      prod_v, prod_o, prod_d;
   logic signed [SW-1:0]    sum_v, sum_o, sum_d;
   logic signed [D_WIDTH-1:0] num_d, den_d, t_nx, t_r;
   logic [D_WIDTH-1:0]      num_abs, den_abs;
   logic                    parallel, div_start, div_busy, div_done, neg, hit_r;
   logic [N-1:0]            quo;
   logic                    out_wr, out_full;
   logic [OUT_W-1:0]        out_head;

   assign in_rd = (state == IDLE) && !in_empty;

   fifo_array #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (in_wr_en),
      .wr_data ({tri_normal, v0, origin, dir}),
      .full    (in_full),
      .rd_en   (in_rd),
      .rd_data (in_head),
      .empty   (in_empty)
   );

   // Sums are kept at 2W+3 bits so the subtraction can never overflow.
   always_comb begin
      sum_v = '0;
      sum_o = '0;
      sum_d = '0;
      for (int i = 0; i < 3; i++) begin
         sum_v = sum_v + SW'($signed(prod_v[i]));
         sum_o = sum_o + SW'($signed(prod_o[i]));
         sum_d = sum_d + SW'($signed(prod_d[i]));
      end
`ifdef P_HIT_SAT_EN
      num_d = D_WIDTH'(sat_w(WIDE'(sum_v - sum_o) >>> Q_BITS, D_WIDTH));
      den_d = D_WIDTH'(sat_w(WIDE'(sum_d) >>> Q_BITS, D_WIDTH));
      t_nx  = D_WIDTH'(sat_w(neg ? -WIDE'(quo) : WIDE'(quo), D_WIDTH));
`else
      num_d = D_WIDTH'((sum_v - sum_o) >>> Q_BITS);
      den_d = D_WIDTH'(sum_d >>> Q_BITS);
      t_nx  = D_WIDTH'(neg ? -quo : quo);
`endif
      num_abs   = D_WIDTH'(abs_w(WIDE'(num_d)));
      den_abs   = D_WIDTH'(abs_w(WIDE'(den_d)));
      parallel  = den_abs < D_WIDTH'(EPS);
      div_start = (state == SUM) && !parallel && !div_busy;
   end

   p_hit_seq_div #(.NW(N), .DW(D_WIDTH)) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend ({num_abs, {Q_BITS{1'b0}}}),
      .divisor  (den_abs),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quo)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         t_r   <= '0;
         hit_r <= 1'b0;
         neg   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (!in_empty) begin
               {op_n, op_v, op_o, op_d} <= in_head;
               state <= MUL;
            end
            MUL: begin
               for (int i = 0; i < 3; i++) begin
                  prod_v[i] <= PW'($signed(op_n[i])) * PW'($signed(op_v[i]));
                  prod_o[i] <= PW'($signed(op_n[i])) * PW'($signed(op_o[i]));
                  prod_d[i] <= PW'($signed(op_n[i])) * PW'($signed(op_d[i]));
               end
               state <= SUM;
            end
            SUM: begin
               neg <= num_d[D_WIDTH-1] ^ den_d[D_WIDTH-1];
               if (parallel) begin
                  t_r   <= '0;
                  hit_r <= 1'b0;
                  state <= WRITE;
               end else if (!div_busy) begin
                  state <= DIV;
               end
            end
            DIV: if (div_done) begin
               t_r   <= t_nx;
               hit_r <= (t_nx > 0);
               state <= WRITE;
            end
            WRITE: if (!out_full) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign out_wr = (state == WRITE) && !out_full;

   fifo_array #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (out_wr),
      .wr_data ({t_r, hit_r}),
      .full    (out_full),
      .rd_en   (out_rd_en),
      .rd_data (out_head),
      .empty   (out_empty)
   );

   assign t_out   = out_empty ? '0 : out_head[OUT_W-1:1];
   assign hit_out = !out_empty && out_head[0];

endmodule

// File: tb/tb_p_hit_t_pipe.sv
// Scoreboard bench for p_hit_t_pipe: directed vectors, backpressure, abort.
module tb_p_hit_t_pipe;
   import p_hit_pkg::*;

   localparam int DW = 32;

   typedef struct packed {
      logic [DW-1:0] t;
      logic          hit;
   } res_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   vec3           tri_normal = '0, v0 = '0, origin = '0, dir = '0;
   logic          in_wr_en = 1'b0, out_rd_en = 1'b0;
   logic          in_full, hit_out, out_empty;
   logic [DW-1:0] t_out;

   res_t sb[$];
   int   n_vec = 0, n_bad = 0;

   always #5 clock = ~clock;

   p_hit_t_pipe dut (
      .clock      (clock),
      .reset      (reset),
      .tri_normal (tri_normal),
      .v0         (v0),
      .origin     (origin),
      .dir        (dir),
      .in_wr_en   (in_wr_en),
      .in_full    (in_full),
      .t_out      (t_out),
      .hit_out    (hit_out),
      .out_empty  (out_empty),
      .out_rd_en  (out_rd_en)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic vec3 v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      vec3 r;
      r[0] = x; r[1] = y; r[2] = z;
      return r;
   endfunction

   function automatic longint fit32(input logic signed [127:0] x);
      logic signed [127:0] mx, mn;
      mx = (128'sd1 <<< 31) - 128'sd1;
      mn = -(128'sd1 <<< 31);
`ifdef P_HIT_SAT_EN
      if (x > mx) return longint'(mx);
      if (x < mn) return longint'(mn);
      return longint'(x);
`else
      return longint'($signed(x[31:0]));
`endif
   endfunction

   // Reference: wide sums, then native 64-bit division on magnitudes.
   function automatic res_t model(input vec3 n, input vec3 a, input vec3 o, input vec3 d);
      logic signed [127:0] sv, so, sd;
      longint ni, nn, dd, an, ad, q;
      res_t r;
      sv = '0; so = '0; sd = '0;
      for (int i = 0; i < 3; i++) begin
         ni = longint'($signed(n[i]));
         sv = sv + 128'(ni * longint'($signed(a[i])));
         so = so + 128'(ni * longint'($signed(o[i])));
         sd = sd + 128'(ni * longint'($signed(d[i])));
      end
      nn = fit32((sv - so) >>> 16);
      dd = fit32(sd >>> 16);
      an = (nn < 0) ? -nn : nn;
      ad = (dd < 0) ? -dd : dd;
      if (ad < 1) begin
         r.t = '0; r.hit = 1'b0;
         return r;
      end
      q = (an <<< 16) / ad;
      if ((nn < 0) != (dd < 0)) q = -q;
      q = fit32(128'(q));
      r.t   = q[31:0];
      r.hit = (q > 0);
      return r;
   endfunction

   task automatic put(input vec3 n, input vec3 a, input vec3 o, input vec3 d);
      tri_normal = n; v0 = a; origin = o; dir = d;
      in_wr_en = 1'b1;
      @(negedge clock);
      in_wr_en = 1'b0;
   endtask

   task automatic get(output int lat);
      res_t r;
      lat = 0;
      while (out_empty && lat < 300) begin
         @(negedge clock);
         lat++;
      end
      if (out_empty) chk("pop_timeout", 64'(out_empty), 64'd0);
      else if (sb.size() == 0) chk("unexpected_out", 64'(out_empty), 64'd1);
      else begin
         r = sb.pop_front();
         chk("t", 64'(t_out), 64'(r.t));
         chk("hit", 64'(hit_out), 64'(r.hit));
         out_rd_en = 1'b1;
         @(negedge clock);
         out_rd_en = 1'b0;
      end
   endtask

   function automatic logic [31:0] rs(input int bits);
      return 32'(int'($urandom_range(0, (1 << (bits + 1)) - 1)) - (1 << bits));
   endfunction

   initial begin
      int   lat, acc, cnt, cyc;
      logic saw_full;
      vec3  bn, ba, bo, bd;
      res_t r;

      repeat (3) @(negedge clock);
      chk("rst_empty", 64'(out_empty), 64'd1);
      chk("rst_full", 64'(in_full), 64'd0);
      chk("rst_t", 64'(t_out), 64'd0);
      chk("rst_hit", 64'(hit_out), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      sb.push_back('{t: 32'h00050000, hit: 1'b1});
      put(v3(0, 0, 32'h10000), v3(0, 0, 32'h50000), '0, v3(0, 0, 32'h10000));
      get(lat);
      chk("lat_normal", 64'(lat), 64'(DIV_ITERS + 4));

      sb.push_back('{t: 32'h0, hit: 1'b0});
      put(v3(0, 0, 32'h10000), v3(0, 0, 32'h50000), '0, v3(32'h10000, 0, 0));
      get(lat);
      chk("lat_parallel", 64'(lat), 64'd4);

      sb.push_back('{t: 32'hFFFB0000, hit: 1'b0});
      put(v3(0, 0, 32'h10000), v3(0, 0, 32'h50000), '0, v3(0, 0, 32'hFFFF0000));
      get(lat);

      sb.push_back('{t: 32'h00008000, hit: 1'b1});
      put(v3(0, 0, 32'h10000), v3(0, 0, 32'h10000), '0, v3(0, 0, 32'h20000));
      get(lat);

`ifdef P_HIT_SAT_EN
      sb.push_back('{t: 32'h7FFFFFFF, hit: 1'b1});
`else
      sb.push_back('{t: 32'h00000000, hit: 1'b0});
`endif
      put(v3(0, 0, 32'h10000), v3(0, 0, 32'h75300000), '0, v3(0, 0, 32'h1));
      get(lat);

      // Abort in the middle of a division; nothing may come out.
      put(v3(0, 0, 32'h10000), v3(0, 0, 32'h50000), '0, v3(0, 0, 32'h10000));
      repeat (20) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (100) @(negedge clock);
      chk("abort_empty", 64'(out_empty), 64'd1);
      sb.push_back('{t: 32'h00030000, hit: 1'b1});
      put(v3(0, 0, 32'h10000), v3(0, 0, 32'h30000), '0, v3(0, 0, 32'h10000));
      get(lat);
      chk("lat_after_abort", 64'(lat), 64'(DIV_ITERS + 4));

      // Backpressure: one attempt every 60 cycles with the output never read.
      acc = 0;
      saw_full = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bn = v3(rs(16), rs(16), 32'h10000);
         ba = v3(rs(20), rs(20), rs(20));
         bo = v3(rs(20), rs(20), rs(20));
         bd = v3(rs(12), rs(12),
                 32'(($urandom_range(0, 1) != 0 ? 1 : -1) * int'($urandom_range(65536, 131072))));
         if (in_full) saw_full = 1'b1;
         else begin
            sb.push_back(model(bn, ba, bo, bd));
            acc++;
         end
         put(bn, ba, bo, bd);
         repeat (59) @(negedge clock);
      end
      chk("saw_full", 64'(saw_full), 64'd1);
      chk("accepted", 64'(acc), 64'd33);

      cnt = 0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 4000) begin
         if (!out_empty) begin
            r = sb.pop_front();
            chk("drain_t", 64'(t_out), 64'(r.t));
            chk("drain_hit", 64'(hit_out), 64'(r.hit));
            cnt++;
            out_rd_en = 1'b1;
         end else begin
            out_rd_en = 1'b0;
         end
         @(negedge clock);
         cyc++;
      end
      out_rd_en = 1'b0;
      chk("drained", 64'(cnt), 64'd33);
      repeat (100) @(negedge clock);
      chk("drain_empty", 64'(out_empty), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
